// File: rtl/platform_pio_poller.sv
// Avalon-MM master that programs a 4-bit input PIO's interrupt mask once, then polls its
// data register on a fixed period or on irq, publishing the value with change/match pulses.
module platform_pio_poller #(
  parameter int DATA_W   = 4,
  parameter int POLL_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] mask_value,
  input  logic [DATA_W-1:0] code,
  input  logic              irq,
  output logic [1:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [31:0]       m_writedata,
  input  logic [31:0]       m_readdata,
  output logic [DATA_W-1:0] value,
  output logic              sample_valid,
  output logic              changed,
  output logic              match,
  output logic              busy
);

  localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(POLL_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT_WR, ST_RD_ADDR, ST_RD_DATA, ST_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              first_q;
  logic [1:0]        addr_q;
  logic              cs_q, wr_n_q, sv_q, chg_q, mt_q, busy_q;
  logic [31:0]       wdata_q;
  logic [DATA_W-1:0] value_q, sample;
  logic              unused_readdata;

  assign sample          = m_readdata[DATA_W-1:0];
  assign unused_readdata = ^m_readdata[31:DATA_W];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (enable) state_d = ST_INIT_WR;
      ST_INIT_WR: state_d = ST_RD_ADDR;
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: state_d = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        // dropping enable wins over a pending poll
        if (!enable)                     state_d = ST_IDLE;
        else if (irq || cnt_q == '0)     state_d = ST_RD_ADDR;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are computed from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      addr_q  <= 2'd0;
      cs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      wdata_q <= '0;
      value_q <= '0;
      sv_q    <= 1'b0;
      chg_q   <= 1'b0;
      mt_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      cs_q    <= (state_d == ST_INIT_WR) || (state_d == ST_RD_ADDR);
      wr_n_q  <= (state_d != ST_INIT_WR);
      addr_q  <= (state_d == ST_INIT_WR) ? 2'd2 : 2'd0;
      wdata_q <= (state_d == ST_INIT_WR) ? 32'(mask_value) : 32'd0;

      sv_q  <= 1'b0;
      chg_q <= 1'b0;
      mt_q  <= 1'b0;
      if (state_q == ST_INIT_WR) first_q <= 1'b1;
      if (state_q == ST_RD_DATA) begin
        value_q <= sample;
        sv_q    <= 1'b1;
        chg_q   <= first_q || (sample != value_q);
        mt_q    <= (sample == code) && (first_q || (value_q != code));
        first_q <= 1'b0;
      end

      if (state_q == ST_RD_DATA)                   cnt_q <= CNT_LOAD;
      else if (state_q == ST_WAIT && cnt_q != '0)  cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign m_address    = addr_q;
  assign m_chipselect = cs_q;
  assign m_write_n    = wr_n_q;
  assign m_writedata  = wdata_q;
  assign value        = value_q;
  assign sample_valid = sv_q;
  assign changed      = chg_q;
  assign match        = mt_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_platform_pio_poller.sv
// Scoreboard bench: a timestamp-level poll schedule model predicts samples and bus activity.
module tb_platform_pio_poller;
  localparam int DW = 4;
  localparam int PD = 8;

  logic          clk = 1'b0, reset_n = 1'b0, enable = 1'b0, irq = 1'b0;
  logic [DW-1:0] mask_value = '0, code = '0, pio = '0;
  logic [1:0]    m_address;
  logic          m_chipselect, m_write_n;
  logic [31:0]   m_writedata;
  logic [31:0]   m_readdata = '0;
  logic [DW-1:0] value;
  logic          sample_valid, changed, match, busy;
  int            checks = 0, failures = 0;

  always #5 clk = ~clk;

  platform_pio_poller #(.DATA_W(DW), .POLL_DIV(PD)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mask_value(mask_value), .code(code),
    .irq(irq), .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .value(value),
    .sample_valid(sample_valid), .changed(changed), .match(match), .busy(busy));

  // Slave: latency-1 registered read of address 0; garbage on the bus otherwise.
  always @(posedge clk) begin
    if (m_chipselect && m_write_n && m_address == 2'd0)
      m_readdata <= ($urandom & 32'hFFFF_FFF0) | 32'(pio);
    else
      m_readdata <= $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: cycle n is the interval following posedge n.
  // md: 0 = idle, 1 = read sequence whose address strobe is in cycle rd_cyc, 2 = waiting since w0.
  typedef struct { int cyc; logic [DW-1:0] v; logic ch; logic mt; } exp_t;
  exp_t          q[$];
  exp_t          ne;
  int            cyc = 0, md = 0, rd_cyc = -10, w0 = 0, init_cyc = -10;
  bit            first = 0;
  logic [DW-1:0] prev = '0, rd_val = '0, init_mask = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md = 0; first = 0; prev = '0; init_cyc = -10; rd_cyc = -10;
      q.delete();
    end else begin
      cyc++;
      case (md)
        0: if (enable) begin
          md = 1; init_cyc = cyc; init_mask = mask_value; rd_cyc = cyc + 1; first = 1;
        end
        1: begin
          if (cyc == rd_cyc + 1) rd_val = pio;
          if (cyc == rd_cyc + 2) begin
            ne.cyc = cyc; ne.v = rd_val;
            ne.ch = first || (rd_val != prev);
            ne.mt = (rd_val == code) && (first || (prev != code));
            q.push_back(ne);
            prev = rd_val; first = 0;
            md = enable ? 2 : 0; w0 = cyc;
          end
        end
        default: begin
          if (!enable) md = 0;
          else if (irq || (cyc - w0) == PD) begin md = 1; rd_cyc = cyc; end
        end
      endcase
    end
  end

  // Monitor: bus/busy every cycle, samples popped from the scoreboard when presented.
  always @(negedge clk) begin
    if (reset_n) begin
      logic wr, rd;
      wr = (cyc == init_cyc);
      rd = (md == 1) && (cyc == rd_cyc);
      chk("bus_busy", 64'({m_chipselect, m_write_n, m_address, m_writedata, busy}),
          64'({wr || rd, !wr, wr ? 2'd2 : 2'd0, wr ? 32'(init_mask) : 32'd0, md != 0}));
      if (sample_valid) begin
        if (q.size() == 0) chk("unexpected_sample", 64'(cyc), 64'hFFFF_FFFF);
        else begin
          ne = q.pop_front();
          chk("sample", {32'(cyc), 26'd0, value, changed, match},
              {32'(ne.cyc), 26'd0, ne.v, ne.ch, ne.mt});
        end
      end else begin
        chk("no_stray_pulse", 64'({changed, match}), 64'd0);
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          ne = q.pop_front();
          chk("missing_sample", 64'(cyc), 64'(ne.cyc));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bus"}, 64'({m_address, m_chipselect, m_write_n, m_writedata}),
        64'({2'd0, 1'b0, 1'b1, 32'd0}));
    chk({tag, "_value"}, 64'(value), 64'd0);
    chk({tag, "_pulses"}, 64'({sample_valid, changed, match}), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit found;
    tick(3);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    tick(2);
    chk_reset_outputs("idle_after_reset");

    // start with mask A, constant data 3, code 5
    pio = 4'h3; code = 4'h5; mask_value = 4'hA; enable = 1'b1;
    tick(40);
    mask_value = 4'h6;      // must not be rewritten while running
    pio = 4'h5;
    tick(30);

    // irq two cycles into a wait window, then held high
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin tick(1); found = sample_valid; end
    if (!found) chk("timeout_sample", 64'd0, 64'd1);
    tick(2); irq = 1'b1; tick(1); irq = 1'b0;
    tick(12);
    pio = 4'h9; irq = 1'b1; tick(15); irq = 1'b0; tick(5);

    // drop enable during the read strobe cycle
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1); found = m_chipselect && m_write_n;
    end
    if (!found) chk("timeout_rd_addr", 64'd0, 64'd1);
    enable = 1'b0;
    tick(6);
    chk("busy_after_drop", 64'(busy), 64'd0);
    enable = 1'b1;
    tick(20);

    // reset during the mask write
    enable = 1'b0; tick(12); enable = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin tick(1); found = !m_write_n; end
    if (!found) chk("timeout_init_wr", 64'd0, 64'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    tick(2);
    #2 reset_n = 1'b1;
    tick(20);

    // randomized run
    for (int i = 0; i < 800; i++) begin
      enable = ($urandom_range(0, 24) != 0);
      irq    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0)  pio = DW'($urandom);
      if ($urandom_range(0, 30) == 0) code = pio;
      if ($urandom_range(0, 9) == 0)  mask_value = DW'($urandom);
      tick(1);
    end
    enable = 1'b0; irq = 1'b0;
    tick(8);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
